// File: rtl/pipelined_addsub_pkg.sv
// Shared defaults and configuration helper for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  // WIDTH must split evenly into at least one slice.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle between operand source, adder pipe and consumer.
interface pipelined_addsub_if
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             Sub;
  logic             in_valid;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] Y;
  logic             Co;
  logic             V;
  logic             Z;

  modport master (
    output A, B, Ci, Sub, in_valid, out_ready,
    input  in_ready, out_valid, Y, Co, V, Z
  );

  modport slave (
    input  A, B, Ci, Sub, in_valid, out_ready,
    output in_ready, out_valid, Y, Co, V, Z
  );

endinterface

// File: rtl/pipelined_addsub_rca_slice.sv
// Combinational ripple-carry slice of SW full-adder cells; exports the carry into the MSB.
module rca_slice #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < SW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[SW];
  assign c_msb = c[SW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple slices with a registered carry between them.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  pipelined_addsub_if.slave  bus
);

  localparam int unsigned SW = (STAGES == 0) ? WIDTH : WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES >= 1");
  end

  // Stage-k inputs: stage 0 takes the bus, later stages take the previous stage's registers.
  logic [WIDTH-1:0] in_a   [STAGES];
  logic [WIDTH-1:0] in_b   [STAGES];
  logic [WIDTH-1:0] in_sum [STAGES];
  logic             in_c   [STAGES];
  logic             in_vld [STAGES];

  logic [WIDTH-1:0] nxt_sum [STAGES];
  logic [SW-1:0]    s_w     [STAGES];
  logic             co_w    [STAGES];
  logic             cm_w    [STAGES];

  logic [WIDTH-1:0] q_a   [STAGES];
  logic [WIDTH-1:0] q_b   [STAGES];
  logic [WIDTH-1:0] q_sum [STAGES];
  logic             q_c   [STAGES];
  logic             q_v   [STAGES];
  logic             q_z   [STAGES];
  logic             q_vld [STAGES];

  logic stall;

  assign stall        = q_vld[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_comb begin
    in_a[0]   = bus.A;
    in_b[0]   = bus.Sub ? ~bus.B : bus.B;
    in_c[0]   = bus.Sub ^ bus.Ci;
    in_sum[0] = '0;
    in_vld[0] = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      in_a[k]   = q_a[k-1];
      in_b[k]   = q_b[k-1];
      in_c[k]   = q_c[k-1];
      in_sum[k] = q_sum[k-1];
      in_vld[k] = q_vld[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_slice #(.SW(SW)) u_slice (
      .a     (in_a[k][k*SW +: SW]),
      .b     (in_b[k][k*SW +: SW]),
      .ci    (in_c[k]),
      .s     (s_w[k]),
      .co    (co_w[k]),
      .c_msb (cm_w[k])
    );
  end

  // Completed slice bits are merged into the deskewed result word as it travels down the pipe.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt_sum[k]              = in_sum[k];
      nxt_sum[k][k*SW +: SW]  = s_w[k];
    end
  end

  // Data registers only load with a valid op, so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        q_vld[k] <= 1'b0;
        q_a[k]   <= '0;
        q_b[k]   <= '0;
        q_sum[k] <= '0;
        q_c[k]   <= 1'b0;
        q_v[k]   <= 1'b0;
        q_z[k]   <= 1'b0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        q_vld[k] <= in_vld[k];
        if (in_vld[k]) begin
          q_a[k]   <= in_a[k];
          q_b[k]   <= in_b[k];
          q_sum[k] <= nxt_sum[k];
          q_c[k]   <= co_w[k];
          q_v[k]   <= cm_w[k] ^ co_w[k];
          q_z[k]   <= (nxt_sum[k] == '0);
        end
      end
    end
  end

  assign bus.out_valid = q_vld[STAGES-1];
  assign bus.Y         = q_sum[STAGES-1];
  assign bus.Co        = q_c[STAGES-1];
  assign bus.V         = q_v[STAGES-1];
  assign bus.Z         = q_z[STAGES-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4) against an arithmetic scoreboard.
module tb_pipelined_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned ST = 4;

  logic clk;
  logic reset;

  pipelined_addsub_if #(.WIDTH(W)) bus ();

  pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         co;
    logic         v;
    logic         z;
    int unsigned  age;
  } op_t;

  op_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Golden: {Co,Y} = A + B' + Ci', V from operand/result signs.
  function automatic op_t golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    op_t r;
    logic [W-1:0] bp;
    logic         cp;
    logic [W:0]   s;
    bp    = sub ? ~b : b;
    cp    = sub ? ~ci : ci;
    s     = {1'b0, a} + {1'b0, bp} + (W+1)'(cp);
    r.y   = s[W-1:0];
    r.co  = s[W];
    r.v   = (a[W-1] == bp[W-1]) && (r.y[W-1] != a[W-1]);
    r.z   = (r.y == '0);
    r.age = 1;
    return r;
  endfunction

  // Compare + model: an op is due at the output once the pipe has advanced ST times since it entered.
  initial begin : compare
    bit           armed;
    bit           exp_v;
    logic         s_reset, s_inv, s_or;
    logic [W-1:0] s_a, s_b;
    logic         s_ci, s_sub;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      s_reset = reset;
      s_inv   = bus.in_valid;
      s_or    = bus.out_ready;
      s_a     = bus.A;
      s_b     = bus.B;
      s_ci    = bus.Ci;
      s_sub   = bus.Sub;
      exp_v   = (q.size() > 0) && (q[0].age >= ST);
      if (armed && !s_reset) begin
        chk("out_valid", bus.out_valid, exp_v);
        chk("in_ready", bus.in_ready, !(exp_v && !s_or));
        if (exp_v) begin
          chk("Y", bus.Y, q[0].y);
          chk("Co", bus.Co, q[0].co);
          chk("V", bus.V, q[0].v);
          chk("Z", bus.Z, q[0].z);
        end
      end
      @(posedge clk);
      if (s_reset) begin
        q.delete();
        armed = 1'b1;
      end else if (armed && !(exp_v && !s_or)) begin
        if (exp_v) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++)
          if (q[i].age < ST) q[i].age++;
        if (s_inv) q.push_back(golden(s_a, s_b, s_ci, s_sub));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sub, input logic vld);
    bus.A = a; bus.B = b; bus.Ci = ci; bus.Sub = sub; bus.in_valid = vld;
  endtask

  logic [W-1:0] exp3 [4];

  initial begin : main
    exp3 = '{16'h0003, 16'h0007, 16'h000B, 16'h000F};
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_Y", bus.Y, 0);
    chk("rst_flags", {bus.Co, bus.V, bus.Z}, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Full-scale carry through every slice.
    cyc();
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    repeat (ST-2) cyc();
    @(negedge clk);
    chk("t1_early_valid", bus.out_valid, 0);
    cyc();
    @(negedge clk);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_Y", bus.Y, 16'h0000);
    chk("t1_CoVZ", {bus.Co, bus.V, bus.Z}, 3'b101);

    // Signed overflow, then subtract with borrow.
    cyc();
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    cyc();
    drive(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    repeat (ST-2) cyc();
    @(negedge clk);
    chk("t2a_Y", bus.Y, 16'h8000);
    chk("t2a_CoVZ", {bus.Co, bus.V, bus.Z}, 3'b010);
    cyc();
    @(negedge clk);
    chk("t2b_Y", bus.Y, 16'hFFFE);
    chk("t2b_CoVZ", {bus.Co, bus.V, bus.Z}, 3'b000);

    // Back-to-back stream.
    cyc();
    repeat (4) cyc();
    for (int i = 0; i < 4; i++) begin
      drive(W'(2*i+1), W'(2*i+2), 1'b0, 1'b0, 1'b1);
      cyc();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_Y", bus.Y, exp3[i]);
      cyc();
    end

    // Stall with full pipe: inputs keep changing but are ignored.
    repeat (3) cyc();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(W'(16'h1000 + i), 16'h0010, 1'b0, 1'b0, 1'b1);
      cyc();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_in_ready", bus.in_ready, 0);
      chk("t4_hold_Y", bus.Y, 16'h1010);
      bus.A = W'($urandom);
      bus.in_valid = 1'b1;
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_drain_valid", bus.out_valid, 1);
      chk("t4_drain_Y", bus.Y, W'(16'h1010 + i));
      cyc();
    end
    @(negedge clk);
    chk("t4_empty", bus.out_valid, 0);

    // Alternating bubbles.
    cyc();
    for (int i = 0; i < 16; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), (i % 2) == 0);
      cyc();
    end
    bus.in_valid = 1'b0;
    repeat (ST+2) cyc();

    // Reset with ops in flight.
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1);
      cyc();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", bus.out_valid, 0);
    repeat (ST+1) cyc();
    drive(16'h1234, 16'h1111, 1'b1, 1'b1, 1'b1);
    cyc();
    bus.in_valid = 1'b0;
    repeat (ST-2) cyc();
    @(negedge clk);
    chk("t6_early_valid", bus.out_valid, 0);
    cyc();
    @(negedge clk);
    chk("t6_valid", bus.out_valid, 1);
    chk("t6_Y", bus.Y, 16'h0122);
    chk("t6_Co", bus.Co, 1);

    // Reset during a stall.
    cyc();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1);
      cyc();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t6s_valid", bus.out_valid, 0);
    chk("t6s_Y", bus.Y, 0);
    chk("t6s_in_ready", bus.in_ready, 1);
    cyc();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = 16'h0000;
      drive(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      bus.out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (ST+3) cyc();
    @(negedge clk);
    chk("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
